// File: rtl/npu_act_pkg.sv
// Shared definitions for the NPU activation stage: mode encodings and default sizes.
package npu_act_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LANES  = 4;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'b00,
        ACT_RELU   = 2'b01,
        ACT_CLIP   = 2'b10,
        ACT_LEAKY  = 2'b11
    } act_mode_e;

endpackage

// File: rtl/npu_act_lane.sv
// Combinational single-lane activation function.
// Mode 11 is leaky ReLU only when NPU_ACT_LEAKY_EN is defined, otherwise it behaves as ReLU.
module npu_act_lane
    import npu_act_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic [DATA_W-1:0] x,
    input  logic [1:0]        mode,
    input  logic              en,
    input  logic [DATA_W-1:0] clip_max,
    output logic [DATA_W-1:0] y,
    output logic              is_neg
);

    logic signed [DATA_W-1:0] xs;
    logic signed [DATA_W-1:0] cs;

    assign xs     = $signed(x);
    assign cs     = $signed(clip_max);
    assign is_neg = en & xs[DATA_W-1];

    function automatic logic signed [DATA_W-1:0] relu_fn(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction

    // A negative ceiling collapses to 0, so every negative clip_max yields 0.
    function automatic logic signed [DATA_W-1:0] clip_fn(input logic signed [DATA_W-1:0] v,
                                                         input logic signed [DATA_W-1:0] c);
        logic signed [DATA_W-1:0] ceil_v;
        ceil_v = relu_fn(c);
        if (v[DATA_W-1])
            return '0;
        else if (v > ceil_v)
            return ceil_v;
        else
            return v;
    endfunction

    // Arithmetic shift floors toward negative infinity, which is the intended rounding.
    function automatic logic signed [DATA_W-1:0] leaky_fn(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? (v >>> LEAKY_SHIFT) : v;
    endfunction

    always_comb begin
        y = '0;
        if (en) begin
            case (act_mode_e'(mode))
                ACT_BYPASS: y = xs;
                ACT_RELU:   y = relu_fn(xs);
                ACT_CLIP:   y = clip_fn(xs, cs);
`ifdef NPU_ACT_LEAKY_EN
                default:    y = leaky_fn(xs);
`else
                default:    y = relu_fn(xs);
`endif
            endcase
        end
    end

endmodule

// File: rtl/npu_act_unit.sv
// Multi-lane activation stage: two-stage valid/ready pipeline plus saturating negative counter.
// Optional leaky mode is controlled by NPU_ACT_LEAKY_EN (see npu_act_lane).
module npu_act_unit
    import npu_act_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LANES       = DEF_LANES,
    parameter int LEAKY_SHIFT = 3,
    parameter int CNT_W       = 16
) (
    input  logic                    CLKEXT,
    input  logic                    RST_GLO,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [1:0]              in_mode,
    input  logic [LANES-1:0]        in_lane_en,
    input  logic [DATA_W-1:0]       clip_max,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        neg_cnt
);

    logic                    vld_p1;
    logic                    vld_p2;
    logic [LANES*DATA_W-1:0] data_p1;
    logic [1:0]              mode_p1;
    logic [LANES-1:0]        en_p1;
    logic [DATA_W-1:0]       clip_p1;
    logic [LANES*DATA_W-1:0] res_p1;
    logic [LANES-1:0]        lane_neg_unused;
    logic                    load_p1;
    logic                    load_p2;
    logic                    accept;
    logic [CNT_W-1:0]        neg_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign load_p2   = !vld_p2 | out_ready;
    assign load_p1   = !vld_p1 | load_p2;
    assign in_ready  = load_p1;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_p2;

    // ---- stage 1: capture the beat and its per-beat controls ----
    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO)
            vld_p1 <= 1'b0;
        else if (load_p1)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge CLKEXT) begin
        if (accept) begin
            data_p1 <= in_data;
            mode_p1 <= in_mode;
            en_p1   <= in_lane_en;
            clip_p1 <= clip_max;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        npu_act_lane #(
            .DATA_W      (DATA_W),
            .LEAKY_SHIFT (LEAKY_SHIFT)
        ) u_lane (
            .x        (data_p1[g*DATA_W +: DATA_W]),
            .mode     (mode_p1),
            .en       (en_p1[g]),
            .clip_max (clip_p1),
            .y        (res_p1[g*DATA_W +: DATA_W]),
            .is_neg   (lane_neg_unused[g])
        );
    end

    // ---- stage 2: register the activated result; it holds while stalled ----
    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            vld_p2   <= 1'b0;
            out_data <= '0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                out_data <= res_p1;
        end
    end

    // Counting happens at the input handshake, so it is independent of downstream stalls.
    always_comb begin
        neg_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_lane_en[i] && in_data[i*DATA_W + DATA_W - 1])
                neg_inc = neg_inc + CNT_W'(1);
        end
    end

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO)
            neg_cnt <= '0;
        else if (cnt_clr)
            neg_cnt <= '0;
        else if (accept && (act_mode_e'(in_mode) != ACT_BYPASS))
            neg_cnt <= sat_add(neg_cnt, neg_inc);
    end

endmodule

// File: tb/tb_npu_act_unit.sv
// Self-checking bench for npu_act_unit: directed steps plus randomized streams against a reference model.
module tb_npu_act_unit;

    localparam int SH  = 3;
    localparam int DIV = 1 << SH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [63:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic [3:0]  in_lane_en = '0;
    logic [15:0] clip_max = '0;

    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [15:0] neg_cnt;
    logic        in_ready4, out_valid4;
    logic [63:0] out_data4;
    logic [3:0]  neg_cnt4;

    int vec_cnt = 0;
    int err_cnt = 0;
    int emit_cnt = 0;

    logic [63:0] exp_q[$];
    int unsigned cnt_m = 0;
    int unsigned cnt4_m = 0;
    int unsigned inc;

    always #5 clk = ~clk;

    npu_act_unit #(.DATA_W(16), .LANES(4), .LEAKY_SHIFT(SH), .CNT_W(16)) dut (
        .CLKEXT(clk), .RST_GLO(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_lane_en(in_lane_en), .clip_max(clip_max),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cnt_clr(cnt_clr), .neg_cnt(neg_cnt)
    );

    npu_act_unit #(.DATA_W(16), .LANES(4), .LEAKY_SHIFT(SH), .CNT_W(4)) dut4 (
        .CLKEXT(clk), .RST_GLO(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_mode(in_mode), .in_lane_en(in_lane_en), .clip_max(clip_max),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .cnt_clr(cnt_clr), .neg_cnt(neg_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vec_cnt++;
        assert (obs === expv) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference activation on plain integers.
    function automatic int act_ref(int x, int mode, bit en, int clip);
        int ceil_v;
        int q;
        if (!en) return 0;
        case (mode)
            0: return x;
            1: return (x < 0) ? 0 : x;
            2: begin
                ceil_v = (clip < 0) ? 0 : clip;
                if (x < 0) return 0;
                return (x > ceil_v) ? ceil_v : x;
            end
            default: begin
`ifdef NPU_ACT_LEAKY_EN
                if (x < 0) begin
                    q = x / DIV;
                    if (q * DIV != x) q = q - 1;
                    return q;
                end
                return x;
`else
                q = 0;
                return (x < 0) ? q : x;
`endif
            end
        endcase
    endfunction

    function automatic logic [63:0] beat_ref(input logic [63:0] d, input logic [1:0] m,
                                             input logic [3:0] e, input logic [15:0] c);
        logic [63:0] r;
        int x;
        int y;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(d[i*16 +: 16]));
            y = act_ref(x, int'(m), e[i], int'($signed(c)));
            r[i*16 +: 16] = 16'(y);
        end
        return r;
    endfunction

    function automatic int unsigned neg_ref(input logic [63:0] d, input logic [1:0] m,
                                            input logic [3:0] e);
        int unsigned n;
        n = 0;
        if (m == 2'b00) return 0;
        for (int i = 0; i < 4; i++)
            if (e[i] && ($signed(d[i*16 +: 16]) < 0)) n++;
        return n;
    endfunction

    // Scoreboard/monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cnt_m = 0;
            cnt4_m = 0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_neg_cnt", 64'(neg_cnt), 64'd0);
        end else begin
            chk("neg_cnt", 64'(neg_cnt), 64'(cnt_m));
            chk("neg_cnt_w4", 64'(neg_cnt4), 64'(cnt4_m));
            chk("in_ready", 64'(in_ready), 64'(!(exp_q.size() >= 2 && !out_ready)));
            if (exp_q.size() == 0)
                chk("out_valid_idle", 64'(out_valid), 64'd0);
            else if (exp_q.size() >= 2)
                chk("out_valid_full", 64'(out_valid), 64'd1);
            if (out_valid && exp_q.size() > 0)
                chk("out_data", out_data, exp_q[0]);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                emit_cnt++;
            end
            inc = 0;
            if (in_valid && in_ready) begin
                exp_q.push_back(beat_ref(in_data, in_mode, in_lane_en, clip_max));
                inc = neg_ref(in_data, in_mode, in_lane_en);
            end
            if (cnt_clr) begin
                cnt_m = 0;
                cnt4_m = 0;
            end else begin
                cnt_m  = (cnt_m + inc > 65535) ? 65535 : cnt_m + inc;
                cnt4_m = (cnt4_m + inc > 15) ? 15 : cnt4_m + inc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        in_data    = {$urandom, $urandom};
        in_mode    = 2'($urandom_range(0, 3));
        in_lane_en = 4'($urandom);
        clip_max   = 16'($urandom);
    endtask

    // Single beat through an empty pipeline with out_ready high; checks latency and data.
    task automatic one_beat(input string tag, input logic [63:0] d, input logic [1:0] m,
                            input logic [3:0] e, input logic [15:0] c, input logic [63:0] expd);
        in_data = d; in_mode = m; in_lane_en = e; clip_max = c; in_valid = 1'b1;
        #1;
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, out_data, expd);
        tick();
        chk({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    task automatic stream(input string tag, input int n, input int budget);
        int acc;
        int cyc;
        acc = 0;
        cyc = 0;
        emit_cnt = 0;
        while (acc < n && cyc < budget) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            rand_beat();
            #1;
            if (in_valid && in_ready) acc++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        chk({tag, "_accepted"}, 64'(acc), 64'(n));
        chk({tag, "_emitted"}, 64'(emit_cnt), 64'(n));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout vectors=%0d", vec_cnt);
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        int acc;
        logic [63:0] leaky_exp;

        // Reset and release
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_neg_cnt", 64'(neg_cnt), 64'd0);
        out_ready = 1'b1;

        // ReLU boundary values
        one_beat("relu", 64'h7FFF_0000_FFFF_8000, 2'b01, 4'hF, 16'h0000, 64'h7FFF_0000_0000_0000);
        chk("relu_neg_cnt", 64'(neg_cnt), 64'd2);

        // Clip with positive and negative ceiling
        one_beat("clip_pos", 64'h0064_FF00_0032_00C8, 2'b10, 4'hF, 16'h0064, 64'h0064_0000_0032_0064);
        one_beat("clip_neg", 64'h0064_FF00_0032_00C8, 2'b10, 4'hF, 16'hFFF0, 64'h0000_0000_0000_0000);
        chk("clip_neg_cnt", 64'(neg_cnt), 64'd4);

        // Leaky rounding toward negative infinity
`ifdef NPU_ACT_LEAKY_EN
        leaky_exp = 64'h0028_FFFE_FFFF_FFFF;
`else
        leaky_exp = 64'h0028_0000_0000_0000;
`endif
        one_beat("leaky", 64'h0028_FFF7_FFF8_FFFF, 2'b11, 4'hF, 16'h0000, leaky_exp);
        chk("leaky_neg_cnt", 64'(neg_cnt), 64'd7);

        // Bypass with disabled lanes does not count
        one_beat("bypass_en", 64'hFFFE_A000_9000_8001, 2'b00, 4'b0101, 16'h0000, 64'h0000_A000_0000_8001);
        chk("bypass_neg_cnt", 64'(neg_cnt), 64'd7);
        chk("bypass_neg_cnt_w4", 64'(neg_cnt4), 64'd7);

        // Full pipeline with out_ready low: exactly two accepts
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            rand_beat();
            #1;
            if (in_ready) acc++;
            tick();
        end
        chk("bp_accepts", 64'(acc), 64'd2);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(); tick(); tick();

        // Randomized streams with random backpressure
        stream("stream10", 10, 200);
        stream("stream200", 200, 3000);

        // Counter saturation at CNT_W=4
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_neg_cnt", 64'(neg_cnt), 64'd0);
        chk("clr_neg_cnt_w4", 64'(neg_cnt4), 64'd0);
        for (int i = 0; i < 3; i++)
            one_beat("sat_pre", 64'h8000_8000_8000_8000, 2'b01, 4'hF, 16'h0000, 64'd0);
        one_beat("sat_15", 64'h0005_8000_8000_8000, 2'b01, 4'hF, 16'h0000, 64'h0005_0000_0000_0000);
        chk("sat_w4_at15", 64'(neg_cnt4), 64'd15);
        one_beat("sat_over", 64'h0007_0009_8000_8000, 2'b10, 4'hF, 16'h0100, 64'h0007_0009_0000_0000);
        chk("sat_w4_hold", 64'(neg_cnt4), 64'd15);
        chk("sat_w16_17", 64'(neg_cnt), 64'd17);

        // Clear wins over a same-cycle negative beat
        in_data = 64'h8000_8000_8000_8000; in_mode = 2'b01; in_lane_en = 4'hF;
        in_valid = 1'b1;
        cnt_clr = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt_clr = 1'b0;
        chk("clr_prio", 64'(neg_cnt), 64'd0);
        chk("clr_prio_w4", 64'(neg_cnt4), 64'd0);
        tick(); tick();

        // Async reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_beat();
        tick();
        rand_beat();
        tick();
        in_valid = 1'b0;
        chk("inflight_full", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_no_emit", 64'(out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/npu_act_unit.md
# npu_act_unit

Parametrised multi-lane activation stage for the NPU datapath, placed between the MAC accumulator registers and the output/writeback buffer. Applies one of four per-beat activation modes (bypass, ReLU, clipped ReLU, leaky ReLU) to LANES signed lanes in parallel. Uses a two-stage valid/ready pipeline with full backpressure and per-lane enables. Keeps a saturating count of negative inputs for profiling.

## Interface
Parameters:
- DATA_W, 16, lane width, two's complement
- LANES, 4, parallel lanes
- LEAKY_SHIFT, 3, arithmetic right-shift amount for leaky mode (0..DATA_W-1)
- CNT_W, 16, width of negative-input counter

Ports:
- CLKEXT  in  1  single clock, rising edge
- RST_GLO  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- in_mode  in  2  activation mode, sampled with the beat
- in_lane_en  in  LANES  per-lane enable, sampled with the beat
- clip_max  in  DATA_W  signed clip ceiling, sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*DATA_W  activated lanes
- cnt_clr  in  1  synchronous clear of neg_cnt
- neg_cnt  out  CNT_W  saturating count of negative enabled lanes

## Operation
- Modes: 00 BYPASS y=x; 01 RELU y = x<0 ? 0 : x; 10 CLIP y = min(max(x,0), max(clip_max,0)); 11 LEAKY y = x<0 ? x>>>LEAKY_SHIFT : x.
- Leaky shift rounds toward negative infinity: -1 -> -1, -8 -> -1 (shift 3), -9 -> -2.
- Negative clip_max clamps CLIP output to 0.
- Lane with in_lane_en=0 outputs 0 in every mode, including BYPASS.
- No arithmetic widens. All results fit in DATA_W, so no saturation logic is needed on the data path.
- Stage 1 registers in_data, mode, lane_en, and clip_max. Stage 2 registers the computed result. out_data is driven directly from the stage-2 register.
- Each stage has a valid bit v1/v2. Stage 2 loads when !v2 | out_ready. Stage 1 loads when !v1 | stage-2 load.
- in_ready = !v1 | !v2 | out_ready. It is combinational from out_ready, with no combinational in->out data path.
- out_data holds stable while out_valid & !out_ready. Beats are never dropped or duplicated, and order is preserved.
- neg_cnt update at each input handshake:
  - Add the number of enabled lanes with x<0 in that beat, in modes 01/10/11 only. BYPASS beats do not count.
  - Saturate at 2^CNT_W-1.
  - cnt_clr has priority: on a clear cycle neg_cnt becomes 0 and that cycle's increment is discarded.

## Timing
- Reset (async assert) clears v1, v2, out_data, and neg_cnt to 0. out_valid=0. in_ready=1 from the first cycle after release.
- Reset mid-operation discards all in-flight beats.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N+1, assuming no stall.
- Throughput: one beat per cycle with out_ready held high.
- Full condition: v1 & v2 & !out_ready forces in_ready=0.
- Simultaneous accept and emit in the same cycle is legal when full with out_ready=1.
- Mode, lane_en, and clip_max travel with their beat. Changing them between beats affects only later beats.

## Configuration
- NPU_ACT_LEAKY_EN:
  - Defined: mode 11 is LEAKY as specified.
  - Undefined: the shifter is removed and mode 11 behaves exactly as RELU (01). Counting is unchanged.

## Structure
- Shared package npu_act_pkg holds:
  - mode encodings ACT_BYPASS=2'b00, ACT_RELU=2'b01, ACT_CLIP=2'b10, ACT_LEAKY=2'b11
  - default DATA_W/LANES constants
- Sub-module npu_act_lane: a purely combinational single-lane function (x, mode, en, clip_max) -> y and is_neg, instantiated LANES times via generate.
- The top holds the pipeline, handshake, and counter.

## Test plan
- Reset then RELU beat, LANES=4, data {0x8000, 0xFFFF, 0x0000, 0x7FFF}, all enabled -> out {0,0,0,0x7FFF} two cycles later; neg_cnt=2.
- CLIP, clip_max=0x0064, data {0x00C8, 0x0032, 0xFF00, 0x0064} -> {0x0064, 0x0032, 0, 0x0064}. Repeat with clip_max=0xFFF0 -> all 0.
- LEAKY with shift 3, data {-1, -8, -9, 40} -> {-1, -1, -2, 40}. With NPU_ACT_LEAKY_EN undefined -> {0, 0, 0, 40}.
- Backpressure:
  - Stream 10 beats with out_ready toggling randomly -> all 10 emitted in order, out_data stable during stalls.
  - With out_ready=0 held, in_ready drops after exactly 2 accepts.
- BYPASS with lane_en=4'b0101, negative data -> lanes 1 and 3 are 0, lanes 0 and 2 pass raw values; neg_cnt unchanged.
- Counter:
  - Preload near saturation with CNT_W=4: 15+2 -> 15.
  - cnt_clr asserted on the same cycle as a negative beat -> neg_cnt=0.
  - Async reset asserted with 2 beats in flight -> out_valid=0 immediately, nothing emitted afterward.
